// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg
//   Shared types for the I/D cache memory arbiter: FSM state encoding,
//   owner encoding and the round-robin winner selection.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // A lone requester always wins. On a tie the requester that was not
  // granted last goes first.
  function automatic owner_e pick_winner(input logic i_req, input logic d_req,
                                         input owner_e last);
    owner_e w;
    if (i_req && d_req) w = (last == OWNER_D) ? OWNER_I : OWNER_D;
    else if (d_req)     w = OWNER_D;
    else                w = OWNER_I;
    return w;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_req_slot.sv
// cache_mem_arbiter_req_slot
//   One request slot per cache channel. A strobe pulse latches the request
//   and raises the pending flag; a grant clears it. The effective request
//   outputs bypass the latch during the strobe cycle so an idle arbiter can
//   issue straight from the cache inputs.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   strobe_i            request pulse from the cache
//   addr_i/rw_i/data_i  request payload, valid with strobe_i
//   grant_i             arbiter consumed this slot's request this cycle
//   req_o               pending or strobing now
//   addr_o/rw_o/data_o  effective request payload
import cache_mem_arbiter_pkg::*;

module cache_mem_arbiter_req_slot #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CACHE_LINE_SIZE = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       strobe_i,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  input  logic                       rw_i,
  input  logic [CACHE_LINE_SIZE-1:0] data_i,
  input  logic                       grant_i,
  output logic                       req_o,
  output logic [ADDR_WIDTH-1:0]      addr_o,
  output logic                       rw_o,
  output logic [CACHE_LINE_SIZE-1:0] data_o
);

  logic                       pend_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic                       rw_q;
  logic [CACHE_LINE_SIZE-1:0] data_q;

  // A cache never strobes while its own request is outstanding, so the
  // strobe can safely take priority over the latched copy.
  assign req_o  = pend_q | strobe_i;
  assign addr_o = strobe_i ? addr_i : addr_q;
  assign rw_o   = strobe_i ? rw_i   : rw_q;
  assign data_o = strobe_i ? data_i : data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      addr_q <= '0;
      rw_q   <= 1'b0;
      data_q <= '0;
    end else if (strobe_i) begin
      addr_q <= addr_i;
      rw_q   <= rw_i;
      data_q <= data_i;
      // Granted in the same cycle it arrived: consumed via the bypass.
      pend_q <= ~grant_i;
    end else if (grant_i) begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one cache-line memory master port between the I-cache (reads
//   only) and D-cache (reads and write-backs). Transactions are serialized
//   through IDLE -> ISSUE -> WAIT -> RESP; ties are broken round-robin.
//   All outputs are registered.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   i_strobe_i, i_addr_i         I-cache line read request
//   i_done_o, i_data_o           I-cache completion pulse + line
//   d_strobe_i, d_addr_i,
//   d_rw_i, d_data_i             D-cache request (rw=1 write-back)
//   d_done_o, d_data_o           D-cache completion pulse + read line
//   m_strobe_o, m_addr_o,
//   m_rw_o, m_data_o             memory master request
//   m_done_i, m_data_i           memory master completion + read line
import cache_mem_arbiter_pkg::*;

module cache_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CACHE_LINE_SIZE = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_strobe_i,
  input  logic [ADDR_WIDTH-1:0]      i_addr_i,
  output logic                       i_done_o,
  output logic [CACHE_LINE_SIZE-1:0] i_data_o,
  input  logic                       d_strobe_i,
  input  logic [ADDR_WIDTH-1:0]      d_addr_i,
  input  logic                       d_rw_i,
  input  logic [CACHE_LINE_SIZE-1:0] d_data_i,
  output logic                       d_done_o,
  output logic [CACHE_LINE_SIZE-1:0] d_data_o,
  output logic                       m_strobe_o,
  output logic [ADDR_WIDTH-1:0]      m_addr_o,
  output logic                       m_rw_o,
  output logic [CACHE_LINE_SIZE-1:0] m_data_o,
  input  logic                       m_done_i,
  input  logic [CACHE_LINE_SIZE-1:0] m_data_i
);

  arb_state_e state_q;
  owner_e     owner_q;
  owner_e     last_grant_q;
  owner_e     winner;

  logic                       i_req, d_req, any_req;
  logic                       i_grant, d_grant;
  logic [ADDR_WIDTH-1:0]      i_addr_eff, d_addr_eff;
  logic                       i_rw_eff, d_rw_eff;
  logic [CACHE_LINE_SIZE-1:0] i_data_eff, d_data_eff;

  // I-cache only reads: its slot carries no direction or write line.
  cache_mem_arbiter_req_slot #(
    .ADDR_WIDTH(ADDR_WIDTH), .CACHE_LINE_SIZE(CACHE_LINE_SIZE)
  ) u_i_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .strobe_i(i_strobe_i),
    .addr_i  (i_addr_i),
    .rw_i    (1'b0),
    .data_i  ({CACHE_LINE_SIZE{1'b0}}),
    .grant_i (i_grant),
    .req_o   (i_req),
    .addr_o  (i_addr_eff),
    .rw_o    (i_rw_eff),
    .data_o  (i_data_eff)
  );

  cache_mem_arbiter_req_slot #(
    .ADDR_WIDTH(ADDR_WIDTH), .CACHE_LINE_SIZE(CACHE_LINE_SIZE)
  ) u_d_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .strobe_i(d_strobe_i),
    .addr_i  (d_addr_i),
    .rw_i    (d_rw_i),
    .data_i  (d_data_i),
    .grant_i (d_grant),
    .req_o   (d_req),
    .addr_o  (d_addr_eff),
    .rw_o    (d_rw_eff),
    .data_o  (d_data_eff)
  );

  assign any_req = i_req | d_req;
  assign winner  = pick_winner(i_req, d_req, last_grant_q);
  assign i_grant = (state_q == ST_IDLE) && i_req && (winner == OWNER_I);
  assign d_grant = (state_q == ST_IDLE) && d_req && (winner == OWNER_D);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_I;
      last_grant_q <= OWNER_D;
      m_strobe_o   <= 1'b0;
      m_addr_o     <= '0;
      m_rw_o       <= 1'b0;
      m_data_o     <= '0;
      i_done_o     <= 1'b0;
      i_data_o     <= '0;
      d_done_o     <= 1'b0;
      d_data_o     <= '0;
    end else begin
      // Pulses default low; each is raised for exactly one state.
      m_strobe_o <= 1'b0;
      i_done_o   <= 1'b0;
      d_done_o   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q    <= winner;
            m_strobe_o <= 1'b1;
            state_q    <= ST_ISSUE;
            if (winner == OWNER_I) begin
              m_addr_o <= i_addr_eff;
              m_rw_o   <= i_rw_eff;
              m_data_o <= i_data_eff;
            end else begin
              m_addr_o <= d_addr_eff;
              m_rw_o   <= d_rw_eff;
              m_data_o <= d_data_eff;
            end
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          // The per-cache data registers double as the response line.
          if (m_done_i) begin
            state_q <= ST_RESP;
            if (owner_q == OWNER_I) begin
              i_done_o <= 1'b1;
              i_data_o <= m_data_i;
            end else begin
              d_done_o <= 1'b1;
              if (!m_rw_o) d_data_o <= m_data_i;
            end
          end
        end
        ST_RESP: begin
          last_grant_q <= owner_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk_i, rst_i;
  logic          i_strobe_i, i_done_o;
  logic [AW-1:0] i_addr_i;
  logic [LW-1:0] i_data_o;
  logic          d_strobe_i, d_rw_i, d_done_o;
  logic [AW-1:0] d_addr_i;
  logic [LW-1:0] d_data_i, d_data_o;
  logic          m_strobe_o, m_rw_o, m_done_i;
  logic [AW-1:0] m_addr_o;
  logic [LW-1:0] m_data_o, m_data_i;

  int checks = 0;
  int errors = 0;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .CACHE_LINE_SIZE(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_strobe_i(i_strobe_i), .i_addr_i(i_addr_i), .i_done_o(i_done_o), .i_data_o(i_data_o),
    .d_strobe_i(d_strobe_i), .d_addr_i(d_addr_i), .d_rw_i(d_rw_i), .d_data_i(d_data_i),
    .d_done_o(d_done_o), .d_data_o(d_data_o),
    .m_strobe_o(m_strobe_o), .m_addr_o(m_addr_o), .m_rw_o(m_rw_o), .m_data_o(m_data_o),
    .m_done_i(m_done_i), .m_data_i(m_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [LW-1:0] rline();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic clear_inputs;
    i_strobe_i = 0; i_addr_i = '0;
    d_strobe_i = 0; d_addr_i = '0; d_rw_i = 0; d_data_i = '0;
    m_done_i = 0; m_data_i = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_i = 1;
    tick(); tick();
    checks++; if (m_strobe_o !== 1'b0) begin errors++; $display("FAIL reset m_strobe: got %b want 0", m_strobe_o); end
    checks++; if (m_addr_o !== '0) begin errors++; $display("FAIL reset m_addr: got %h want 0", m_addr_o); end
    checks++; if (m_rw_o !== 1'b0) begin errors++; $display("FAIL reset m_rw: got %b want 0", m_rw_o); end
    checks++; if (m_data_o !== '0) begin errors++; $display("FAIL reset m_data: got %h want 0", m_data_o); end
    checks++; if (i_done_o !== 1'b0 || d_done_o !== 1'b0) begin errors++; $display("FAIL reset done: got i=%b d=%b want 0", i_done_o, d_done_o); end
    checks++; if (i_data_o !== '0 || d_data_o !== '0) begin errors++; $display("FAIL reset data_o: got i=%h d=%h want 0", i_data_o, d_data_o); end
    rst_i = 0;
    tick();
    checks++; if (m_strobe_o !== 1'b0) begin errors++; $display("FAIL reset idle m_strobe: got %b want 0", m_strobe_o); end
  endtask

  task automatic test_single_i_read;
    logic [LW-1:0] line;
    line = {32{8'hA5}};
    do_reset();
    i_strobe_i = 1; i_addr_i = 32'h8000_0100;           // cycle t
    tick(); i_strobe_i = 0; i_addr_i = 32'h0;            // t+1
    checks++; if (m_strobe_o !== 1'b1) begin errors++; $display("FAIL single_i m_strobe: got %b want 1", m_strobe_o); end
    checks++; if (m_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL single_i m_addr: got %h want 80000100", m_addr_o); end
    checks++; if (m_rw_o !== 1'b0) begin errors++; $display("FAIL single_i m_rw: got %b want 0", m_rw_o); end
    tick();                                               // t+2
    checks++; if (m_strobe_o !== 1'b0) begin errors++; $display("FAIL single_i strobe width: got %b want 0", m_strobe_o); end
    tick(); tick(); tick();                               // t+5
    m_done_i = 1; m_data_i = line;
    tick(); m_done_i = 0; m_data_i = '0;                  // t+6
    checks++; if (i_done_o !== 1'b1) begin errors++; $display("FAIL single_i i_done: got %b want 1", i_done_o); end
    checks++; if (i_data_o !== line) begin errors++; $display("FAIL single_i i_data: got %h want %h", i_data_o, line); end
    checks++; if (d_done_o !== 1'b0) begin errors++; $display("FAIL single_i d_done: got %b want 0", d_done_o); end
    checks++; if (m_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL single_i m_addr hold: got %h want 80000100", m_addr_o); end
    tick();                                               // t+7
    checks++; if (i_done_o !== 1'b0) begin errors++; $display("FAIL single_i i_done width: got %b want 0", i_done_o); end
  endtask

  task automatic test_d_writeback;
    logic [LW-1:0] wl;
    wl = {8{32'h1234_5678}};
    do_reset();
    d_strobe_i = 1; d_addr_i = 32'h8000_0200; d_rw_i = 1; d_data_i = wl;
    tick(); d_strobe_i = 0; d_addr_i = '0; d_rw_i = 0; d_data_i = '0;
    checks++; if (m_strobe_o !== 1'b1 || m_addr_o !== 32'h8000_0200) begin errors++; $display("FAIL d_wb issue: got strobe=%b addr=%h want 1/80000200", m_strobe_o, m_addr_o); end
    checks++; if (m_rw_o !== 1'b1) begin errors++; $display("FAIL d_wb m_rw: got %b want 1", m_rw_o); end
    checks++; if (m_data_o !== wl) begin errors++; $display("FAIL d_wb m_data: got %h want %h", m_data_o, wl); end
    tick(); tick();
    m_done_i = 1;
    tick(); m_done_i = 0;
    checks++; if (d_done_o !== 1'b1 || i_done_o !== 1'b0) begin errors++; $display("FAIL d_wb done: got d=%b i=%b want 1/0", d_done_o, i_done_o); end
    checks++; if (m_data_o !== wl || m_rw_o !== 1'b1) begin errors++; $display("FAIL d_wb hold: got rw=%b data=%h", m_rw_o, m_data_o); end
    tick();
    checks++; if (d_done_o !== 1'b0) begin errors++; $display("FAIL d_wb done width: got %b want 0", d_done_o); end
  endtask

  task automatic test_tie_round_robin;
    logic [LW-1:0] l1, l2;
    l1 = rline(); l2 = rline();
    do_reset();
    i_strobe_i = 1; i_addr_i = 32'h1000_0040;
    d_strobe_i = 1; d_addr_i = 32'h2000_0080; d_rw_i = 0;
    tick(); clear_inputs();
    checks++; if (m_strobe_o !== 1'b1 || m_addr_o !== 32'h1000_0040) begin errors++; $display("FAIL tie1 first: got strobe=%b addr=%h want I 10000040", m_strobe_o, m_addr_o); end
    tick();
    m_done_i = 1; m_data_i = l1;                          // u
    tick(); clear_inputs();                               // u+1
    checks++; if (i_done_o !== 1'b1 || i_data_o !== l1) begin errors++; $display("FAIL tie1 i_done: got %b data=%h", i_done_o, i_data_o); end
    tick();                                               // u+2
    checks++; if (m_strobe_o !== 1'b0) begin errors++; $display("FAIL tie1 u+2 strobe: got %b want 0", m_strobe_o); end
    tick();                                               // u+3
    checks++; if (m_strobe_o !== 1'b1 || m_addr_o !== 32'h2000_0080 || m_rw_o !== 1'b0) begin errors++; $display("FAIL tie1 second: got strobe=%b addr=%h rw=%b want D 20000080", m_strobe_o, m_addr_o, m_rw_o); end
    tick();
    m_done_i = 1; m_data_i = l2;
    tick(); clear_inputs();
    checks++; if (d_done_o !== 1'b1 || d_data_o !== l2) begin errors++; $display("FAIL tie1 d_done: got %b data=%h", d_done_o, d_data_o); end
    tick();
    // Lone I request so that I was granted last before the next tie.
    i_strobe_i = 1; i_addr_i = 32'h1000_00C0;
    tick(); clear_inputs();
    checks++; if (m_strobe_o !== 1'b1 || m_addr_o !== 32'h1000_00C0) begin errors++; $display("FAIL rr lone I: got strobe=%b addr=%h", m_strobe_o, m_addr_o); end
    tick(); m_done_i = 1; m_data_i = l1;
    tick(); clear_inputs();
    tick();
    i_strobe_i = 1; i_addr_i = 32'h1000_0100;
    d_strobe_i = 1; d_addr_i = 32'h2000_0100; d_rw_i = 0;
    tick(); clear_inputs();
    checks++; if (m_strobe_o !== 1'b1 || m_addr_o !== 32'h2000_0100) begin errors++; $display("FAIL tie2 first: got strobe=%b addr=%h want D 20000100", m_strobe_o, m_addr_o); end
    tick(); m_done_i = 1; m_data_i = l2;
    tick(); clear_inputs();
    checks++; if (d_done_o !== 1'b1) begin errors++; $display("FAIL tie2 d_done: got %b want 1", d_done_o); end
    tick(); tick();
    checks++; if (m_strobe_o !== 1'b1 || m_addr_o !== 32'h1000_0100) begin errors++; $display("FAIL tie2 second: got strobe=%b addr=%h want I 10000100", m_strobe_o, m_addr_o); end
    tick(); m_done_i = 1; m_data_i = l1;
    tick(); clear_inputs();
    checks++; if (i_done_o !== 1'b1 || i_data_o !== l1) begin errors++; $display("FAIL tie2 i_done: got %b data=%h", i_done_o, i_data_o); end
    tick();
  endtask

  task automatic test_capture_during_wait;
    logic [LW-1:0] wl;
    wl = rline();
    do_reset();
    i_strobe_i = 1; i_addr_i = 32'h3000_0000;
    tick(); clear_inputs();                               // ISSUE
    tick();                                               // WAIT
    d_strobe_i = 1; d_addr_i = 32'h4000_0020; d_rw_i = 1; d_data_i = wl;
    tick();
    d_strobe_i = 0; d_addr_i = 32'hDEAD_BEE0; d_rw_i = 0; d_data_i = ~wl;
    tick();
    m_done_i = 1; m_data_i = rline();                     // u
    tick(); m_done_i = 0;
    checks++; if (i_done_o !== 1'b1 || d_done_o !== 1'b0) begin errors++; $display("FAIL capture i_done: got i=%b d=%b want 1/0", i_done_o, d_done_o); end
    tick(); tick();                                       // u+3
    checks++; if (m_strobe_o !== 1'b1 || m_addr_o !== 32'h4000_0020) begin errors++; $display("FAIL capture d issue: got strobe=%b addr=%h want 1/40000020", m_strobe_o, m_addr_o); end
    checks++; if (m_rw_o !== 1'b1 || m_data_o !== wl) begin errors++; $display("FAIL capture d payload: got rw=%b data=%h want 1/%h", m_rw_o, m_data_o, wl); end
    tick(); m_done_i = 1;
    tick(); m_done_i = 0;
    checks++; if (d_done_o !== 1'b1) begin errors++; $display("FAIL capture d_done: got %b want 1", d_done_o); end
    tick();
  endtask

  task automatic test_spurious_done;
    do_reset();
    m_done_i = 1; m_data_i = rline();
    tick(); clear_inputs();
    checks++; if (i_done_o !== 1'b0 || d_done_o !== 1'b0 || m_strobe_o !== 1'b0) begin errors++; $display("FAIL spurious: got i=%b d=%b s=%b want 0", i_done_o, d_done_o, m_strobe_o); end
    tick();
    checks++; if (i_done_o !== 1'b0 || d_done_o !== 1'b0) begin errors++; $display("FAIL spurious late: got i=%b d=%b want 0", i_done_o, d_done_o); end
    i_strobe_i = 1; i_addr_i = 32'h5000_0000;
    tick(); clear_inputs();
    checks++; if (m_strobe_o !== 1'b1) begin errors++; $display("FAIL spurious still idle: got strobe=%b want 1", m_strobe_o); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    i_strobe_i = 1; i_addr_i = 32'h6000_0040;
    tick(); clear_inputs();                               // ISSUE
    tick();                                               // WAIT
    d_strobe_i = 1; d_addr_i = 32'h7000_0000; d_rw_i = 1; d_data_i = rline();
    tick(); clear_inputs();
    rst_i = 1;
    #1;
    checks++; if (m_addr_o !== '0 || m_strobe_o !== 1'b0 || m_rw_o !== 1'b0) begin errors++; $display("FAIL rst_mid outputs: got addr=%h s=%b rw=%b want 0", m_addr_o, m_strobe_o, m_rw_o); end
    checks++; if (i_done_o !== 1'b0 || d_done_o !== 1'b0) begin errors++; $display("FAIL rst_mid done: got i=%b d=%b want 0", i_done_o, d_done_o); end
    tick();
    rst_i = 0;
    m_done_i = 1; m_data_i = rline();
    tick(); clear_inputs();
    for (int k = 0; k < 5; k++) begin
      checks++; if (i_done_o !== 1'b0 || d_done_o !== 1'b0 || m_strobe_o !== 1'b0) begin errors++; $display("FAIL rst_mid after[%0d]: got i=%b d=%b s=%b want 0", k, i_done_o, d_done_o, m_strobe_o); end
      tick();
    end
  endtask

  // Random traffic against a transaction-level model: the memory is free
  // two cycles after its completion, an idle arbiter issues one cycle after
  // it sees a request, ties go to whoever was not served last.
  task automatic test_random;
    bit i_out, d_out, iw, dw, act, arw, drw;
    int own, last, iss_c, mdone_c, done_c, free_at;
    logic [AW-1:0] ia, da, aa;
    logic [LW-1:0] dd, adat, line;
    i_out = 0; d_out = 0; iw = 0; dw = 0; act = 0; arw = 0; drw = 0;
    own = 0; last = 1; iss_c = -1; mdone_c = -1; done_c = -1; free_at = 0;
    ia = '0; da = '0; aa = '0; dd = '0; adat = '0; line = '0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      checks++; if (m_strobe_o !== (iss_c == c)) begin errors++; $display("FAIL rnd c%0d m_strobe: got %b want %b", c, m_strobe_o, iss_c == c); end
      if (iss_c == c) begin
        checks++; if (m_addr_o !== aa || m_rw_o !== arw || m_data_o !== adat) begin errors++; $display("FAIL rnd c%0d issue: got addr=%h rw=%b want addr=%h rw=%b", c, m_addr_o, m_rw_o, aa, arw); end
      end
      checks++; if (i_done_o !== (done_c == c && own == 0)) begin errors++; $display("FAIL rnd c%0d i_done: got %b", c, i_done_o); end
      checks++; if (d_done_o !== (done_c == c && own == 1)) begin errors++; $display("FAIL rnd c%0d d_done: got %b", c, d_done_o); end
      if (done_c == c) begin
        if (own == 0) begin
          checks++; if (i_data_o !== line) begin errors++; $display("FAIL rnd c%0d i_data: got %h want %h", c, i_data_o, line); end
          i_out = 0;
        end else begin
          if (!arw) begin
            checks++; if (d_data_o !== line) begin errors++; $display("FAIL rnd c%0d d_data: got %h want %h", c, d_data_o, line); end
          end
          d_out = 0;
        end
      end
      i_strobe_i = 0; d_strobe_i = 0; m_done_i = 0;
      i_addr_i = $urandom(); d_addr_i = $urandom(); d_rw_i = 1'($urandom_range(0, 1)); d_data_i = rline();
      if (act && mdone_c == c) begin
        line = rline(); m_done_i = 1; m_data_i = line;
        done_c = c + 1; free_at = c + 2; act = 0; last = own;
      end else if (!act && $urandom_range(0, 19) == 0) begin
        m_done_i = 1; m_data_i = rline();
      end
      if (!i_out && $urandom_range(0, 3) == 0) begin
        i_out = 1; iw = 1; ia = $urandom(); i_strobe_i = 1; i_addr_i = ia;
      end
      if (!d_out && $urandom_range(0, 3) == 0) begin
        d_out = 1; dw = 1; da = $urandom(); drw = 1'($urandom_range(0, 1)); dd = rline();
        d_strobe_i = 1; d_addr_i = da; d_rw_i = drw; d_data_i = dd;
      end
      if (!act && c >= free_at && (iw || dw)) begin
        own = (iw && dw) ? ((last == 1) ? 0 : 1) : (iw ? 0 : 1);
        if (own == 0) begin aa = ia; arw = 0; adat = '0; iw = 0; end
        else begin aa = da; arw = drw; adat = dd; dw = 0; end
        act = 1; iss_c = c + 1; mdone_c = c + 1 + $urandom_range(1, 6);
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst_i = 1;
    clear_inputs();
    test_reset();
    test_single_i_read();
    test_d_writeback();
    test_tie_round_robin();
    test_capture_during_wait();
    test_spurious_done();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares one cache-line-wide memory master port between the I-cache and D-cache line-fill/write-back channels of the Aquila SoC. The block sits between the two cache master interfaces and the single AXI master IP that fronts DDRx DRAM. It serializes transactions, grants round-robin when both caches are waiting, and returns registered done/data to the owning cache.

## Interface
- ADDR_WIDTH, 32, address bus width
- CACHE_LINE_SIZE, 256, cache line width in bits
- clk_i  in  1  system clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- i_strobe_i  in  1  I-cache line-read request, single-cycle pulse
- i_addr_i  in  ADDR_WIDTH  I-cache line address, valid with i_strobe_i
- i_done_o  out  1  one-cycle pulse, I-cache line delivered
- i_data_o  out  CACHE_LINE_SIZE  I-cache line, valid while i_done_o
- d_strobe_i  in  1  D-cache request, single-cycle pulse
- d_addr_i  in  ADDR_WIDTH  D-cache line address
- d_rw_i  in  1  1 = write-back, 0 = line read
- d_data_i  in  CACHE_LINE_SIZE  write-back line, valid with d_strobe_i
- d_done_o  out  1  one-cycle pulse, D-cache transaction complete
- d_data_o  out  CACHE_LINE_SIZE  read line, valid while d_done_o
- m_strobe_o  out  1  one-cycle pulse to memory master
- m_addr_o  out  ADDR_WIDTH  registered transaction address
- m_rw_o  out  1  registered direction; 0 for I-cache
- m_data_o  out  CACHE_LINE_SIZE  registered write line
- m_done_i  in  1  one-cycle pulse, memory transaction complete
- m_data_i  in  CACHE_LINE_SIZE  read line, valid with m_done_i

## Operation
- Each requester issues at most one outstanding transaction; never strobes again before its own done.
- Request capture: strobe pulse sets pending flag and latches addr (and rw/data for D) into a per-requester slot; flag cleared when granted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any pending flag (or a same-cycle strobe) -> choose winner, load m_addr/m_rw/m_data from its slot, record owner -> ISSUE.
- Winner: only one pending -> that one; both pending -> the one not granted last (last_grant flag). After reset last_grant = D, so I-cache wins first tie.
- ISSUE: m_strobe_o = 1 for exactly this cycle -> WAIT.
- WAIT: on m_done_i -> register m_data_i into response line, -> RESP. Otherwise hold.
- RESP: owner's done_o = 1, owner's data_o = registered line (I read or D read; D write returns done only, data don't-care) -> IDLE; update last_grant = owner.
- m_done_i in IDLE, ISSUE or RESP is ignored (no state change, no done out).
- Strobe from the non-owner during ISSUE/WAIT/RESP is captured in its slot and served next.
- m_addr_o/m_rw_o/m_data_o hold stable from ISSUE until leaving RESP.

## Timing
- Reset values: all outputs 0; state IDLE; pending flags 0; last_grant = D.
- Reset mid-transaction: immediate return to IDLE, pending requests dropped, late m_done_i ignored; caches are reset by the same rst_i.
- Strobe in cycle t with memory idle -> m_strobe_o in t+1 (ISSUE).
- m_done_i in cycle u -> requester done_o in u+1 (RESP).
- Back-to-back: next m_strobe_o no earlier than u+3 (IDLE at u+2, ISSUE at u+3).
- Arbitration overhead: 3 cycles per transaction beyond memory latency.
- Simultaneous i_strobe_i and d_strobe_i in IDLE: tie rule applies; loser pending, served immediately after.
- No combinational path from any input to any output.

## Structure
- Shared package: FSM state encoding (IDLE, ISSUE, WAIT, RESP) and owner encoding (OWNER_I = 0, OWNER_D = 1).
- One sub-module is natural: req_slot, instantiated twice. It holds the pending flag plus latched addr/rw/data, with capture-on-strobe and clear-on-grant.
- The D instance carries rw and data; the I instance ties rw = 0 and data = 0.

## Test plan
- Single I read: i_strobe_i at t, addr 0x8000_0100; m_done_i at t+5 with line 0xA5.. -> m_strobe_o at t+1, m_addr_o 0x8000_0100, m_rw_o 0; i_done_o at t+6 with line; d_done_o stays 0.
- D write-back: d_strobe_i, rw 1, addr 0x8000_0200, data 0x1234.. -> m_rw_o 1, m_data_o 0x1234..; after m_done_i, d_done_o pulse one cycle.
- Simultaneous strobes after reset -> I served first, D issued at u+3 after I's m_done_i at u. A second simultaneous pair then serves D first (round-robin).
- D strobe during I WAIT -> captured. I completes, then D issued with its original addr/data unchanged even though d_addr_i has changed since.
- Spurious m_done_i in IDLE -> no done outputs, state stays IDLE.
- rst_i asserted in WAIT with D pending -> outputs 0 immediately. After release, a late m_done_i yields no done, and no transaction is issued.
